// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-bus controller: state encodings and command constants.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_BUS  = 3'd2,
        RD_BUS  = 3'd3,
        RD_HOLD = 3'd4
    } ctrlState_t;

    localparam int         CMD_RD_BIT      = 7;
    localparam logic [6:0] STATUS_ADDR     = 7'h7F;
    localparam logic [7:0] TIMEOUT_FILL    = 8'hEE;
    localparam int         ACK_TIMEOUT_DEF = 15;
    localparam int         TMR_W           = 4;

    function automatic logic [7:0] statusByte(input logic errT, input logic errO);
        return {6'b0, errT, errO};
    endfunction

endpackage

// File: rtl/spi_reg_timeout.sv
// Loadable down-counter for bus-ack timeouts; expired marks the last allowed cycle of a request.
module spi_reg_timeout
    import spi_reg_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/spi_reg_ctrl.sv
// Packet-level controller between spi_slave and the register bus.
// Optional status byte preload when SPI_REG_CTRL_STATUS_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, no packet decoded yet
// WR_WAIT | write packet, waiting for the next data byte
// WR_BUS  | regWr held, waiting for regAck or timeout
// RD_BUS  | read packet, issuing/holding regRd for the prefetch
// RD_HOLD | txData loaded, waiting for spi_slave to consume it
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int AUTO_INC    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rxDataIn,
    input  logic              rxDataRdySet,
    input  logic              rxPacketStart,
    input  logic              txDataFullClr,
    output logic [7:0]        txData,
    output logic              txDataFull,
    output logic [ADDR_W-1:0] regAddr,
    output logic [7:0]        regWrData,
    output logic              regWr,
    output logic              regRd,
    input  logic [7:0]        regRdData,
    input  logic              regAck,
    output logic              errOverrun,
    output logic              errTimeout
);

    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(AUTO_INC);
    localparam logic [ADDR_W-1:0] STATUS_AREG = ADDR_W'(STATUS_ADDR);

    ctrlState_t        state;
    logic [ADDR_W-1:0] addr;
    logic              cmdStrobe;
    logic              dataStrobe;
    logic              busy;
    logic              tmrExpired;

    assign cmdStrobe  = rxDataRdySet && rxPacketStart;
    assign dataStrobe = rxDataRdySet && !rxPacketStart;
    assign busy       = regWr || regRd;
    assign regAddr    = addr;

    // Counter sits loaded while the bus is quiet, so every request starts with a full budget.
    spi_reg_timeout #(
        .W(TMR_W)
    ) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .load    (!busy),
        .loadVal (TMR_W'(ACK_TIMEOUT)),
        .en      (busy && !regAck),
        .expired (tmrExpired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            txData     <= '0;
            txDataFull <= 1'b0;
            regWrData  <= '0;
            regWr      <= 1'b0;
            regRd      <= 1'b0;
            errOverrun <= 1'b0;
            errTimeout <= 1'b0;
        end else begin
            if (txDataFullClr) begin
                txDataFull <= 1'b0;
            end

            if (cmdStrobe) begin
                // A new command always wins, even over an ack arriving in the same cycle.
                regWr      <= 1'b0;
                regRd      <= 1'b0;
                txDataFull <= 1'b0;
                addr       <= rxDataIn[ADDR_W-1:0];
                state      <= rxDataIn[CMD_RD_BIT] ? RD_BUS : WR_WAIT;
            end else begin
                case (state)
                    IDLE: begin
`ifdef SPI_REG_CTRL_STATUS_EN
                        if (!txDataFull) begin
                            txData     <= statusByte(errTimeout, errOverrun);
                            txDataFull <= 1'b1;
                        end
`endif
                    end

                    WR_WAIT: begin
                        if (dataStrobe) begin
                            if (addr == STATUS_AREG) begin
                                errOverrun <= 1'b0;
                                errTimeout <= 1'b0;
                            end else begin
                                regWrData <= rxDataIn;
                                regWr     <= 1'b1;
                                state     <= WR_BUS;
                            end
                        end
`ifdef SPI_REG_CTRL_STATUS_EN
                        if (!txDataFull) begin
                            txData     <= statusByte(errTimeout, errOverrun);
                            txDataFull <= 1'b1;
                        end
`endif
                    end

                    WR_BUS: begin
                        if (regAck) begin
                            regWr <= 1'b0;
                            addr  <= addr + ADDR_STEP;
                            state <= WR_WAIT;
                        end else if (tmrExpired) begin
                            regWr      <= 1'b0;
                            errTimeout <= 1'b1;
                            state      <= WR_WAIT;
                        end
                        if (dataStrobe) begin
                            errOverrun <= 1'b1;
                        end
                    end

                    RD_BUS: begin
                        // First cycle here raises regRd; addr is already settled.
                        if (!regRd) begin
                            regRd <= 1'b1;
                        end else if (regAck) begin
                            regRd      <= 1'b0;
                            txData     <= regRdData;
                            txDataFull <= 1'b1;
                            state      <= RD_HOLD;
                        end else if (tmrExpired) begin
                            regRd      <= 1'b0;
                            errTimeout <= 1'b1;
                            txData     <= TIMEOUT_FILL;
                            txDataFull <= 1'b1;
                            state      <= RD_HOLD;
                        end
                    end

                    RD_HOLD: begin
                        if (txDataFullClr) begin
                            txDataFull <= 1'b0;
                            addr       <= addr + ADDR_STEP;
                            state      <= RD_BUS;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
